// File: rtl/fx_rate_arith.sv
// fx_rate_arith
//   Fixed-point arithmetic and step-rate clock helper for the stepper motion path.
//   Number format is Q(N-1-Q).Q sign-magnitude: bit N-1 sign, N-2..0 magnitude.
//   Outputs never carry -0; a zero magnitude is always emitted with sign 0.
//
//   Functions:
//     - bit-serial restoring divider, one quotient bit per cycle, N-1+Q cycles
//     - combinational sign-magnitude adder
//     - toggle clock divider, period 2*(clkdiv_max_in+1)
//
//   Build option: define FX_RATE_SAT_EN to saturate overflowed magnitudes to
//   all-ones (sign kept). Without it the low N-1 magnitude bits are returned.
//   A zero divisor always yields magnitude all-ones. Overflow flags are the
//   same in both builds.
//
//   Ports:
//     clk_in, rst_in          clock, asynchronous active-high reset
//     div_start_in            start a division (sampled while idle)
//     div_dividend_in/_divisor_in   operands
//     div_quotient_out        registered quotient, held until next result
//     div_complete_out        level: result valid
//     div_overflow_out        result overflowed or divisor was zero
//     add_a_in, add_b_in      adder operands
//     add_sum_out             combinational sum
//     add_overflow_out        magnitude carry-out (same-sign path only)
//     clkdiv_max_in           half-period minus one
//     clkdiv_clk_out          divided clock
module fx_rate_arith #(
    parameter int N  = 64,
    parameter int Q  = 32,
    parameter int CW = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          div_start_in,
    input  logic [N-1:0]  div_dividend_in,
    input  logic [N-1:0]  div_divisor_in,
    output logic [N-1:0]  div_quotient_out,
    output logic          div_complete_out,
    output logic          div_overflow_out,
    input  logic [N-1:0]  add_a_in,
    input  logic [N-1:0]  add_b_in,
    output logic [N-1:0]  add_sum_out,
    output logic          add_overflow_out,
    input  logic [CW-1:0] clkdiv_max_in,
    output logic          clkdiv_clk_out
);

    localparam int M    = N - 1;        // magnitude width
    localparam int ITER = N - 1 + Q;    // numerator width and iteration count
    localparam int CNTW = $clog2(ITER + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [ITER-1:0]   nq_q, nq_d;      // numerator bits shift out, quotient bits shift in
    logic [M-1:0]      rem_q, rem_d;
    logic [M-1:0]      dvs_q, dvs_d;
    logic              sgn_q, sgn_d;
    logic [N-1:0]      quo_q, quo_d;
    logic              cmp_q, cmp_d;
    logic              ovf_q, ovf_d;

    logic [M:0]        rem_shift;
    logic [M-1:0]      rem_sub;
    logic              q_bit;
    logic [ITER-1:0]   nq_next;
    logic              div_zero;
    logic              res_ovf;
    logic [M-1:0]      res_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        cmp_d   = cmp_q;
        ovf_d   = ovf_q;

        rem_shift = {rem_q, nq_q[ITER-1]};
        q_bit     = rem_shift >= {1'b0, dvs_q};
        // When q_bit is set the true difference is below dvs_q, so the low
        // M bits of the modular subtraction are exact.
        rem_sub   = rem_shift[M-1:0] - dvs_q;
        nq_next   = {nq_q[ITER-2:0], q_bit};
        div_zero  = (dvs_q == '0);
        res_ovf   = (|nq_next[ITER-1:M]) | div_zero;
`ifdef FX_RATE_SAT_EN
        res_mag   = res_ovf ? '1 : nq_next[M-1:0];
`else
        res_mag   = div_zero ? '1 : nq_next[M-1:0];
`endif

        case (state_q)
            S_IDLE: begin
                if (div_start_in) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    nq_d    = {div_dividend_in[M-1:0], {Q{1'b0}}};
                    rem_d   = '0;
                    dvs_d   = div_divisor_in[M-1:0];
                    sgn_d   = div_dividend_in[N-1] ^ div_divisor_in[N-1];
                    cmp_d   = 1'b0;
                end
            end
            S_BUSY: begin
                rem_d = q_bit ? rem_sub : rem_shift[M-1:0];
                nq_d  = nq_next;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(ITER - 1)) begin
                    state_d = S_IDLE;
                    quo_d   = {sgn_q & (|res_mag), res_mag};
                    ovf_d   = res_ovf;
                    cmp_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            cmp_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            cmp_q   <= cmp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign div_quotient_out = quo_q;
    assign div_complete_out = cmp_q;
    assign div_overflow_out = ovf_q;

    // ------------------------------------------------------------------
    // Adder
    // ------------------------------------------------------------------
    logic [M-1:0] a_mag, b_mag, diff_mag, sum_mag;
    logic [M:0]   sum_full;
    logic         a_ge_b, sum_sgn, sum_ovf;

    always_comb begin
        a_mag    = add_a_in[M-1:0];
        b_mag    = add_b_in[M-1:0];
        sum_full = {1'b0, a_mag} + {1'b0, b_mag};
        a_ge_b   = a_mag >= b_mag;
        diff_mag = a_ge_b ? (a_mag - b_mag) : (b_mag - a_mag);
        sum_ovf  = 1'b0;
        if (add_a_in[N-1] == add_b_in[N-1]) begin
            sum_ovf = sum_full[M];
            sum_sgn = add_a_in[N-1];
`ifdef FX_RATE_SAT_EN
            sum_mag = sum_full[M] ? '1 : sum_full[M-1:0];
`else
            sum_mag = sum_full[M-1:0];
`endif
        end else begin
            sum_sgn = a_ge_b ? add_a_in[N-1] : add_b_in[N-1];
            sum_mag = diff_mag;
        end
    end

    assign add_sum_out      = {sum_sgn & (|sum_mag), sum_mag};
    assign add_overflow_out = sum_ovf;

    // ------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic          cclk_q, cclk_d;

    always_comb begin
        ccnt_d = ccnt_q + CW'(1);
        cclk_d = cclk_q;
        // >= rather than == so a lowered max takes effect on the next edge.
        if (ccnt_q >= clkdiv_max_in) begin
            ccnt_d = '0;
            cclk_d = ~cclk_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ccnt_q <= '0;
            cclk_q <= 1'b0;
        end else begin
            ccnt_q <= ccnt_d;
            cclk_q <= cclk_d;
        end
    end

    assign clkdiv_clk_out = cclk_q;

endmodule

// File: tb/tb_fx_rate_arith.sv
module tb_fx_rate_arith;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic [63:0] div_dividend, div_divisor, div_quotient;
    logic        div_complete, div_overflow;
    logic [63:0] add_a, add_b, add_sum;
    logic        add_overflow;
    logic [31:0] clkdiv_max;
    logic        clkdiv_clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    typedef struct packed {
        logic [63:0] q;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fx_rate_arith #(.N(64), .Q(32), .CW(32)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .div_start_in     (div_start),
        .div_dividend_in  (div_dividend),
        .div_divisor_in   (div_divisor),
        .div_quotient_out (div_quotient),
        .div_complete_out (div_complete),
        .div_overflow_out (div_overflow),
        .add_a_in         (add_a),
        .add_b_in         (add_b),
        .add_sum_out      (add_sum),
        .add_overflow_out (add_overflow),
        .clkdiv_max_in    (clkdiv_max),
        .clkdiv_clk_out   (clkdiv_clk)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] q, input logic ovf);
        exp_t e;
        e.q   = q;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_quot"}, div_quotient, e.q);
            chk({tag, "_ovf"}, {63'd0, div_overflow}, {63'd0, e.ovf});
        end
    endtask

    // One pulsed division: checks busy behaviour, latency, then scoreboard result.
    task automatic run_div(input string tag, input logic [63:0] dd, input logic [63:0] dv,
                           input logic [63:0] eq, input logic eo);
        int unsigned edges;
        logic [63:0] prev_q;
        logic        stable;
        push_exp(eq, eo);
        prev_q       = div_quotient;
        div_dividend = dd;
        div_divisor  = dv;
        div_start    = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        chk({tag, "_cmp_clr"}, {63'd0, div_complete}, 64'd0);
        edges  = 0;
        stable = 1'b1;
        while (!div_complete && edges < 200) begin
            @(negedge clk);
            edges++;
            if (!div_complete && div_quotient !== prev_q) stable = 1'b0;
        end
        chk({tag, "_latency"}, 64'(edges), 64'd95);
        chk({tag, "_hold_busy"}, {63'd0, stable}, 64'd1);
        pop_chk(tag);
    endtask

    task automatic chk_add(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] es, input logic eo);
        add_a = a;
        add_b = b;
        #1;
        chk({tag, "_sum"}, add_sum, es);
        chk({tag, "_ovf"}, {63'd0, add_overflow}, {63'd0, eo});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, width;
        logic prev, stable, seen;

        rst = 1'b1; div_start = 1'b0; div_dividend = '0; div_divisor = '0;
        add_a = '0; add_b = '0; clkdiv_max = 32'd12;
        @(negedge clk); @(negedge clk);
        chk("rst_quot", div_quotient, 64'd0);
        chk("rst_ovf", {63'd0, div_overflow}, 64'd0);
        chk("rst_cmp", {63'd0, div_complete}, 64'd0);
        chk("rst_clk", {63'd0, clkdiv_clk}, 64'd0);

        // Clock divider, max=12: first toggle at edge 13, then 13 high, 13 low.
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!clkdiv_clk && n < 100);
        chk("clk_first_toggle", 64'(n), 64'd13);
        n = 0;
        while (clkdiv_clk && n < 100) begin @(negedge clk); n++; end
        chk("clk_high_len", 64'(n), 64'd13);
        n = 0;
        while (!clkdiv_clk && n < 100) begin @(negedge clk); n++; end
        chk("clk_low_len", 64'(n), 64'd13);

        // max=0: toggles every edge.
        clkdiv_max = 32'd0;
        prev = clkdiv_clk;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("clk_div2", {63'd0, clkdiv_clk}, {63'd0, ~prev});
            prev = ~prev;
        end

        // max 100 -> 5 at count 50: toggle on the next edge.
        rst = 1'b1; clkdiv_max = 32'd100;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("clk_lower_before", {63'd0, clkdiv_clk}, 64'd0);
        clkdiv_max = 32'd5;
        @(negedge clk);
        chk("clk_lower_toggle", {63'd0, clkdiv_clk}, 64'd1);
        repeat (5) @(negedge clk);
        chk("clk_lower_hold", {63'd0, clkdiv_clk}, 64'd1);
        @(negedge clk);
        chk("clk_lower_next", {63'd0, clkdiv_clk}, 64'd0);
        clkdiv_max = 32'd12;

        // Adder
        chk_add("add_20050m2", 64'h00004E52_00000000, 64'h80000002_00000000, 64'h00004E50_00000000, 1'b0);
        chk_add("add_1m1", 64'h00000001_00000000, 64'h80000001_00000000, 64'h0, 1'b0);
        chk_add("add_m1p1", 64'h80000001_00000000, 64'h00000001_00000000, 64'h0, 1'b0);
        chk_add("add_2m5", 64'h00000002_00000000, 64'h80000005_00000000, 64'h80000003_00000000, 1'b0);
        chk_add("add_m1m2", 64'h80000001_00000000, 64'h80000002_00000000, 64'h80000003_00000000, 1'b0);
        chk_add("add_negzero", 64'h80000000_00000000, 64'h80000000_00000000, 64'h0, 1'b0);
`ifdef FX_RATE_SAT_EN
        chk_add("add_carry", 64'h40000000_00000000, 64'h40000000_00000001, 64'h7FFFFFFF_FFFFFFFF, 1'b1);
        chk_add("add_carry_neg", 64'hC0000000_00000000, 64'hC0000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
`else
        chk_add("add_carry", 64'h40000000_00000000, 64'h40000000_00000001, 64'h00000000_00000001, 1'b1);
        chk_add("add_carry_neg", 64'hC0000000_00000000, 64'hC0000000_00000000, 64'h0, 1'b1);
`endif

        // Divider
        @(negedge clk);
        run_div("div_2p0", 64'h00004E20_00000000, 64'h00002710_00000000, 64'h00000002_00000000, 1'b0);
        run_div("div_signed", 64'h80000003_00000000, 64'h00000001_80000000, 64'h80000002_00000000, 1'b0);
        run_div("div_zero", 64'h00000001_00000000, 64'h0, 64'h7FFFFFFF_FFFFFFFF, 1'b1);
        run_div("div_negzero", 64'h00000001_00000000, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        run_div("div_zero_res", 64'h80000000_00000000, 64'h00000001_00000000, 64'h0, 1'b0);
`ifdef FX_RATE_SAT_EN
        run_div("div_ovf", 64'h40000000_00000000, 64'h00000000_00000001, 64'h7FFFFFFF_FFFFFFFF, 1'b1);
`else
        run_div("div_ovf", 64'h40000000_00000000, 64'h00000000_00000001, 64'h0, 1'b1);
`endif
        run_div("div_pre", 64'h00004E20_00000000, 64'h00002710_00000000, 64'h00000002_00000000, 1'b0);

        // Reset 40 cycles into a division: outputs clear at once, no result follows.
        div_dividend = 64'h00000003_00000000;
        div_divisor  = 64'h00000001_00000000;
        div_start    = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_quot", div_quotient, 64'd0);
        chk("abort_cmp", {63'd0, div_complete}, 64'd0);
        chk("abort_ovf", {63'd0, div_overflow}, 64'd0);
        chk("abort_clk", {63'd0, clkdiv_clk}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (div_complete) seen = 1'b1;
        end
        chk("abort_no_result", {63'd0, seen}, 64'd0);
        run_div("div_after_abort", 64'h80000003_00000000, 64'h00000001_80000000, 64'h80000002_00000000, 1'b0);

        // Held start: one-cycle complete pulse every 96 cycles, quotient stable.
        div_dividend = 64'h00004E20_00000000;
        div_divisor  = 64'h00002710_00000000;
        div_start    = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(64'h00000002_00000000, 1'b0);
        @(negedge clk);
        n = 0;
        while (!div_complete && n < 200) begin @(negedge clk); n++; end
        chk("hold_first_latency", 64'(n), 64'd95);
        pop_chk("hold0");
        for (int k = 0; k < 2; k++) begin
            n = 0; width = 1; stable = 1'b1;
            while (div_complete && n < 300) begin
                @(negedge clk); n++;
                if (div_complete) width++;
            end
            while (!div_complete && n < 300) begin
                @(negedge clk); n++;
                if (div_quotient !== 64'h00000002_00000000) stable = 1'b0;
            end
            chk("hold_period", 64'(n), 64'd96);
            chk("hold_width", 64'(width), 64'd1);
            chk("hold_stable", {63'd0, stable}, 64'd1);
            pop_chk("hold");
        end
        div_start = 1'b0;
        @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
